// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage.
// ALU op codes, RV32I opcode/funct3 values, FSM states, decode bundle.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_SUM   = 4'b0010;
  localparam logic [3:0] OP_EQUAL = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_GE    = 4'b1100;
  localparam logic [3:0] OP_GEU   = 4'b1101;
  localparam logic [3:0] OP_SLT   = 4'b1110;
  localparam logic [3:0] OP_SLTU  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    A_REG  = 2'd0,
    A_ZERO = 2'd1,
    A_PC   = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    B_REG   = 2'd0,
    B_IMM   = 2'd1,
    B_SHAMT = 2'd2
  } b_sel_t;

  typedef struct packed {
    logic [3:0] op;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic       is_branch;
    logic       br_on_zero;
    logic       illegal;
  } dec_t;

  // funct3 (+alt bit for SUB/SRA) to ALU op for OP / OP-IMM
  function automatic logic [3:0] arith_op(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    case (f3)
      F3_ADD:  op = alt ? OP_SUB : OP_SUM;
      F3_SLL:  op = OP_SLL;
      F3_SLT:  op = OP_SLT;
      F3_SLTU: op = OP_SLTU;
      F3_XOR:  op = OP_XOR;
      F3_SR:   op = alt ? OP_SRA : OP_SRL;
      F3_OR:   op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU op, operand selects,
// branch polarity and illegal flag.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Illegal encodings fall through as SUM of rs1 and rs2.
  always_comb begin
    dec = '{op: OP_SUM, a_sel: A_REG, b_sel: B_REG,
            is_branch: 1'b0, br_on_zero: 1'b0,
            illegal: 1'b1};
    case (opc)
      OPC_OP: begin
        if (f7 == 7'b0000000 ||
            (f7 == 7'b0100000 &&
             (f3 == F3_ADD || f3 == F3_SR))) begin
          dec.op      = arith_op(f3, f7[5]);
          dec.illegal = 1'b0;
        end
      end
      OPC_IMM: begin
        dec.op = arith_op(f3, f3 == F3_SR && instr[30]);
        dec.b_sel = (f3 == F3_SLL || f3 == F3_SR) ?
                    B_SHAMT : B_IMM;
        dec.illegal = 1'b0;
      end
      OPC_LOAD: begin
        if (f3 inside {3'b000, 3'b001, 3'b010,
                       3'b100, 3'b101}) begin
          dec.b_sel   = B_IMM;
          dec.illegal = 1'b0;
        end
      end
      OPC_STORE: begin
        if (f3 inside {3'b000, 3'b001, 3'b010}) begin
          dec.b_sel   = B_IMM;
          dec.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.a_sel   = A_ZERO;
        dec.b_sel   = B_IMM;
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a_sel   = A_PC;
        dec.b_sel   = B_IMM;
        dec.illegal = 1'b0;
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          dec.is_branch = 1'b1;
          dec.illegal   = 1'b0;
          case (f3)
            F3_BEQ: begin
              dec.op         = OP_SUB;
              dec.br_on_zero = 1'b1;
            end
            F3_BNE:  dec.op = OP_SUB;
            F3_BLT:  dec.op = OP_SLT;
            F3_BGE:  dec.op = OP_GE;
            F3_BLTU: dec.op = OP_SLTU;
            default: dec.op = OP_GEU;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: registers decoded op/operands onto the ALU, captures
// result and branch outcome. Optional: ALU_ISSUE_ILLEGAL_EN.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_i,
  output logic [3:0]  ALU_OP_o,
  output logic [31:0] ALU_RS1_o,
  output logic [31:0] ALU_RS2_o,
  input  logic [31:0] ALU_RD_i,
  input  logic        ALU_ZR_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        branch_taken_o,
  output logic        illegal_o
);

  state_t      state;
  state_t      state_nx;
  dec_t        dec;
  logic        accept;
  logic [31:0] a_val;
  logic [31:0] b_val;
  logic        br_q;
  logic        on_zero_q;
  logic        taken;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        ill_q;
`endif

  alu_issue_decode u_dec (
    .instr (instr_i),
    .dec   (dec)
  );

  assign in_ready_o  = (state == S_IDLE) ||
                       (state == S_DONE && out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state == S_DONE);
  assign taken       = br_q &
                       (on_zero_q ? ALU_ZR_i : !ALU_ZR_i);

  // Next state: DONE may chain straight into EXEC.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_EXEC;
      S_EXEC: state_nx = S_DONE;
      S_DONE: begin
        if (out_ready_i)
          state_nx = accept ? S_EXEC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Operand muxing from decoder selects.
  always_comb begin
    a_val = rs1_i;
    b_val = rs2_i;
    case (dec.a_sel)
      A_ZERO:  a_val = '0;
      A_PC:    a_val = pc_i;
      default: ;
    endcase
    case (dec.b_sel)
      B_IMM:   b_val = imm_i;
      B_SHAMT: b_val = {27'd0, imm_i[4:0]};
      default: ;
    endcase
  end

  // ALU inputs and branch info latched only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_OP_o  <= OP_AND;
      ALU_RS1_o <= '0;
      ALU_RS2_o <= '0;
      br_q      <= 1'b0;
      on_zero_q <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      ill_q     <= 1'b0;
`endif
    end else if (accept) begin
      ALU_OP_o  <= dec.op;
      ALU_RS1_o <= a_val;
      ALU_RS2_o <= b_val;
      br_q      <= dec.is_branch;
      on_zero_q <= dec.br_on_zero;
`ifdef ALU_ISSUE_ILLEGAL_EN
      ill_q     <= dec.illegal;
`endif
    end
  end

  // Result capture at the end of EXEC; held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o       <= '0;
      branch_taken_o <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_o      <= 1'b0;
`endif
    end else if (state == S_EXEC) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
      result_o       <= ill_q ? 32'd0 : ALU_RD_i;
      branch_taken_o <= taken & !ill_q;
      illegal_o      <= ill_q;
`else
      result_o       <= ALU_RD_i;
      branch_taken_o <= taken;
`endif
    end
  end

`ifndef ALU_ISSUE_ILLEGAL_EN
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed table, hand sequences
// and random instructions against a behavioural reference.
module tb_alu_issue;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, rs1, rs2, imm, pc;
  logic [3:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic        alu_zr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        taken;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .instr_i        (instr),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .imm_i          (imm),
    .pc_i           (pc),
    .ALU_OP_o       (alu_op),
    .ALU_RS1_o      (alu_rs1),
    .ALU_RS2_o      (alu_rs2),
    .ALU_RD_i       (alu_rd),
    .ALU_ZR_i       (alu_zr),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result),
    .branch_taken_o (taken),
    .illegal_o      (illegal)
  );

  // Combinational ALU seen by the stage.
  function automatic logic [31:0] alu_f(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return {31'd0, a == b};
      4'h4: return a << b[4:0];
      4'h5: return a >> b[4:0];
      4'h7: return $signed(a) >>> b[4:0];
      4'h8: return a ^ b;
      4'h9: return ~(a | b);
      4'hA: return a - b;
      4'hC: return {31'd0, $signed(a) >= $signed(b)};
      4'hD: return {31'd0, a >= b};
      4'hE: return {31'd0, $signed(a) < $signed(b)};
      4'hF: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_rd = alu_f(alu_op, alu_rs1, alu_rs2);
  assign alu_zr = (alu_rd == 32'd0);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tk;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  function automatic logic [3:0] f3op(input logic [2:0] f3,
                                      input logic alt);
    case (f3)
      3'd0: return alt ? 4'hA : 4'h2;
      3'd1: return 4'h4;
      3'd2: return 4'hE;
      3'd3: return 4'hF;
      3'd4: return 4'h8;
      3'd5: return alt ? 4'h7 : 4'h5;
      3'd6: return 4'h1;
      default: return 4'h0;
    endcase
  endfunction

  // Reference: what the instruction means, with branch outcome
  // taken from the comparison it names.
  function automatic exp_t model(
    input logic [31:0] ins, input logic [31:0] x,
    input logic [31:0] y, input logic [31:0] im,
    input logic [31:0] p);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    e = '{op: 4'h2, a: x, b: y, res: 32'd0, tk: 1'b0, ill: 1'b1};
    case (opc)
      7'h33: if (f7 == 7'h00 ||
                 (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.ill = 1'b0;
        e.op  = f3op(f3, f7[5]);
      end
      7'h13: begin
        e.ill = 1'b0;
        e.op  = f3op(f3, f3 == 3'd5 && ins[30]);
        e.b   = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, im[4:0]} : im;
      end
      7'h03: if (f3 != 3'd3 && f3 < 3'd6) begin
        e.ill = 1'b0; e.b = im;
      end
      7'h23: if (f3 < 3'd3) begin
        e.ill = 1'b0; e.b = im;
      end
      7'h37: begin e.ill = 1'b0; e.a = 32'd0; e.b = im; end
      7'h17: begin e.ill = 1'b0; e.a = p; e.b = im; end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        e.ill = 1'b0;
        case (f3)
          3'd0: begin e.op = 4'hA; e.tk = (x == y); end
          3'd1: begin e.op = 4'hA; e.tk = (x != y); end
          3'd4: begin e.op = 4'hE; e.tk = $signed(x) < $signed(y); end
          3'd5: begin e.op = 4'hC; e.tk = $signed(x) >= $signed(y); end
          3'd6: begin e.op = 4'hF; e.tk = x < y; end
          default: begin e.op = 4'hD; e.tk = x >= y; end
        endcase
      end
      default: ;
    endcase
    e.res = alu_f(e.op, e.a, e.b);
    if (e.ill && ILL_EN) e.res = 32'd0;
    if (!ILL_EN) e.ill = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] m,
                       input logic [31:0] p);
    instr = i; rs1 = a; rs2 = b; imm = m; pc = p;
  endtask

  // One full transaction from an idle stage; called #1 after an edge.
  task automatic run_one(input vec_t v, input string tag,
                         input int stall);
    int n;
    logic rdy;
    drive(v.instr, v.rs1, v.rs2, v.imm, v.pc);
    in_valid = 1'b1;
    n = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 10);
    in_valid = 1'b0;
    if (!rdy) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
    chk({tag, ".op"}, {28'd0, alu_op}, {28'd0, v.e.op});
    chk({tag, ".rs1"}, alu_rs1, v.e.a);
    chk({tag, ".rs2"}, alu_rs2, v.e.b);
    chk({tag, ".exec_valid"}, {31'd0, out_valid}, 32'd0);
    n = 0;
    @(posedge clk); #1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, 0);
    chk({tag, ".res"}, result, v.e.res);
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, v.e.tk});
    chk({tag, ".ill"}, {31'd0, illegal}, {31'd0, v.e.ill});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_res"}, result, v.e.res);
      chk({tag, ".hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7,
                                      input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    logic [6:0] opcs [9];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37,
             7'h17, 7'h63, 7'h63, 7'h7F};

    vt.push_back('{enc(7'h00, 3'd0, 7'h33), 32'd5, 32'd7, 32'd0, 32'd0,
      '{4'h2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd4, 7'h63), 32'hFFFFFFFF, 32'd1, 32'd0,
      32'd0, '{4'hE, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd6, 7'h63), 32'hFFFFFFFF, 32'd1, 32'd0,
      32'd0, '{4'hF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h20, 3'd5, 7'h13), 32'h80000000, 32'h55,
      32'h404, 32'd0,
      '{4'h7, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd0, 7'h37), 32'hDEAD, 32'd1,
      32'h12345000, 32'd0,
      '{4'h2, 32'd0, 32'h12345000, 32'h12345000, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd0, 7'h17), 32'd8, 32'd9, 32'h2000,
      32'h1000, '{4'h2, 32'h1000, 32'h2000, 32'h3000, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd0, 7'h63), 32'd9, 32'd9, 32'd0, 32'd0,
      '{4'hA, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd1, 7'h63), 32'd9, 32'd9, 32'd0, 32'd0,
      '{4'hA, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd5, 7'h63), 32'hFFFFFFFF, 32'd1, 32'd0,
      32'd0, '{4'hC, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h20, 3'd0, 7'h33), 32'd3, 32'd5, 32'd0, 32'd0,
      '{4'hA, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd2, 7'h03), 32'h100, 32'd1,
      32'hFFFFFFFC, 32'd0,
      '{4'h2, 32'h100, 32'hFFFFFFFC, 32'hFC, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h20, 3'd1, 7'h13), 32'd1, 32'd0,
      32'hFFFFFFE3, 32'd0, '{4'h4, 32'd1, 32'd3, 32'd8, 1'b0, 1'b0}});
    vt.push_back('{enc(7'h00, 3'd0, 7'h7F), 32'd3, 32'd4, 32'd0, 32'd0,
      '{4'h2, 32'd3, 32'd4, ILL_EN ? 32'd0 : 32'd7, 1'b0, ILL_EN}});
    vt.push_back('{enc(7'h00, 3'd2, 7'h63), 32'd2, 32'd2, 32'd0, 32'd0,
      '{4'h2, 32'd2, 32'd2, ILL_EN ? 32'd0 : 32'd4, 1'b0, ILL_EN}});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.op", {28'd0, alu_op}, 32'd0);
    chk("rst.rs1", alu_rs1, 32'd0);
    chk("rst.rs2", alu_rs2, 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.taken", {31'd0, taken}, 32'd0);
    chk("rst.ill", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i])
      run_one(vt[i], $sformatf("vec%0d", i), 0);

    // Stall, ignored valid while blocked, then chained accept.
    v = vt[0];
    drive(v.instr, v.rs1, v.rs2, v.imm, v.pc);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall.valid", {31'd0, out_valid}, 32'd1);
    drive(enc(7'h00, 3'd4, 7'h33), 32'hF0F0, 32'h0FF0, 32'd0, 32'd0);
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk("stall.valid", {31'd0, out_valid}, 32'd1);
      chk("stall.res", result, 32'd12);
      chk("stall.rdy", {31'd0, in_ready}, 32'd0);
      chk("stall.op", {28'd0, alu_op}, 32'h2);
    end
    out_ready = 1'b1;
    #1;
    chk("chain.rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("chain.exec_valid", {31'd0, out_valid}, 32'd0);
    chk("chain.op", {28'd0, alu_op}, 32'h8);
    chk("chain.rs1", alu_rs1, 32'hF0F0);
    @(posedge clk); #1;
    chk("chain.valid", {31'd0, out_valid}, 32'd1);
    chk("chain.res", result, 32'hFF00);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while in EXEC discards the instruction.
    drive(v.instr, v.rs1, v.rs2, v.imm, v.pc);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid.op", {28'd0, alu_op}, 32'd0);
    chk("mid.rs1", alu_rs1, 32'd0);
    chk("mid.res", result, 32'd0);
    chk("mid.rdy", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk("mid.no_out", {31'd0, out_valid}, 32'd0);
    end

    // Random instructions against the reference model.
    for (int k = 0; k < 200; k++) begin
      int sel;
      sel = $urandom_range(0, 8);
      v.instr = $urandom;
      v.instr[6:0] = opcs[sel];
      if (sel == 0) begin
        case ($urandom_range(0, 3))
          0, 1: v.instr[31:25] = 7'h00;
          2:    v.instr[31:25] = 7'h20;
          default: ;
        endcase
      end
      v.rs1 = $urandom;
      v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
      if ($urandom_range(0, 3) == 0) v.rs2 = $urandom_range(0, 40);
      v.imm = $urandom;
      v.pc  = $urandom & 32'hFFFFFFFC;
      e = model(v.instr, v.rs1, v.rs2, v.imm, v.pc);
      v.e = e;
      run_one(v, $sformatf("rnd%0d", k), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
